// File: rtl/booth_multiplier_seq_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
// Contents:
//   state_t    - control FSM states (IDLE, CALC, DONE)
//   digit_t    - encodings of the recoded radix-4 digit {-2,-1,0,+1,+2}
//   calc_iter  - number of radix-4 steps needed for a given operand width
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        D_ZERO = 3'd0,
        D_POS1 = 3'd1,
        D_POS2 = 3'd2,
        D_NEG1 = 3'd3,
        D_NEG2 = 3'd4
    } digit_t;

    // One step per operand bit pair, plus one extra step so that the two
    // extension bits of the zero-extended unsigned operand are consumed too.
    function automatic int calc_iter(input int width);
        return (width / 32'sd2) + 32'sd1;
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Handshake bundle between the issue stage and the Booth multiplier.
// Ports (master = requester/consumer side, slave = multiplier side):
//   in_valid/in_ready       - operand handshake
//   multiplicand/multiplier - WIDTH-bit operands, is_signed selects mode
//   out_valid/out_ready     - result handshake
//   product                 - 2*WIDTH-bit result
//   busy                    - multiplier is working on or holding a result
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          multiplicand;
    logic [WIDTH-1:0]          multiplier;
    logic                      is_signed;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*WIDTH-1:0]        product;
    logic                      busy;

    modport master (
        output in_valid, multiplicand, multiplier, is_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, is_signed, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/booth_multiplier_seq_recoder.sv
// Combinational radix-4 Booth recoder.
// Ports:
//   window - {q[i+1], q[i], q[i-1]} bits of the multiplier shift register
//   m      - multiplicand already extended to WIDTH+2 bits
//   pp     - partial product d*M, d in {-2,-1,0,+1,+2}, WIDTH+2 bits
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+1:0] pp
);

    localparam logic [WIDTH+1:0] PP_ONE  = {{(WIDTH+1){1'b0}}, 1'b1};
    localparam logic [WIDTH+1:0] PP_ZERO = {(WIDTH+2){1'b0}};

    digit_t           digit;
    logic [WIDTH+1:0] m_x2;

    // M carries two copies of its sign bit, so dropping the top one when
    // doubling loses no information.
    assign m_x2 = {m[WIDTH:0], 1'b0};

    // Map the 3-bit overlapping window to its Booth digit.
    always_comb begin
        digit = D_ZERO;
        case (window)
            3'b000:  digit = D_ZERO;
            3'b001:  digit = D_POS1;
            3'b010:  digit = D_POS1;
            3'b011:  digit = D_POS2;
            3'b100:  digit = D_NEG2;
            3'b101:  digit = D_NEG1;
            3'b110:  digit = D_NEG1;
            3'b111:  digit = D_ZERO;
            default: digit = D_ZERO;
        endcase
    end

    // Select the partial product for the digit; negation is two's complement.
    always_comb begin
        pp = PP_ZERO;
        case (digit)
            D_ZERO:  pp = PP_ZERO;
            D_POS1:  pp = m;
            D_POS2:  pp = m_x2;
            D_NEG1:  pp = ~m + PP_ONE;
            D_NEG2:  pp = ~m_x2 + PP_ONE;
            default: pp = PP_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier, one recoded digit per clock.
// Ports:
//   clk   - single rising-edge clock
//   rst_n - synchronous active-low reset; aborts any transaction in flight
//   bus   - slave side of booth_multiplier_seq_if (operand/result handshakes)
// Flow: IDLE accepts operands, CALC runs ITER Booth steps, DONE presents the
// product until the consumer takes it. The product register keeps its last
// value through IDLE; consumers qualify it with out_valid.
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int RESULT_WIDTH = 32'sd2 * WIDTH,
    parameter int ITER         = calc_iter(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_multiplier_seq_if.slave bus
);

    localparam int EXT_W = WIDTH + 32'sd2;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

    generate
        if (((WIDTH % 32'sd2) != 32'sd0) || (WIDTH < 32'sd4)) begin : g_bad_width
            $error("booth_multiplier_seq: WIDTH must be even and >= 4");
        end
        if (RESULT_WIDTH != (32'sd2 * WIDTH)) begin : g_bad_result_width
            $error("booth_multiplier_seq: RESULT_WIDTH must equal 2*WIDTH");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [EXT_W-1:0]        m_q, m_d;
    logic [EXT_W:0]          q_q, q_d;      // {Q, q[-1]}
    logic [EXT_W-1:0]        acc_q, acc_d;
    logic [RESULT_WIDTH-1:0] product_q, product_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    logic [EXT_W-1:0]        pp;
    logic [EXT_W+1:0]        sum;
    logic [EXT_W-1:0]        acc_nx;
    logic [EXT_W:0]          q_nx;
    logic                    ext_a;
    logic                    ext_b;

    booth_r4_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .window (q_q[2:0]),
        .m      (m_q),
        .pp     (pp)
    );

    // Sign bits used to extend the operands: zero in unsigned mode.
    assign ext_a = bus.is_signed & bus.multiplicand[WIDTH-1];
    assign ext_b = bus.is_signed & bus.multiplier[WIDTH-1];

    // One Booth step: add d*M to the accumulator, then arithmetic-shift
    // {acc, Q, q[-1]} right by two. The sum is formed two bits wider than the
    // accumulator so the transient before the shift cannot wrap; after the
    // shift the value is back in range of the accumulator.
    always_comb begin
        sum    = {{2{acc_q[EXT_W-1]}}, acc_q} + {{2{pp[EXT_W-1]}}, pp};
        acc_nx = sum[EXT_W+1:2];
        q_nx   = {sum[1:0], q_q[EXT_W:2]};
    end

    // Next-state and datapath control for IDLE / CALC / DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    m_d     = {{2{ext_a}}, bus.multiplicand};
                    q_d     = {{2{ext_b}}, bus.multiplier, 1'b0};
                    acc_d   = {EXT_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = acc_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Low 2*WIDTH bits of the final {acc, Q}.
                    product_d = {acc_nx[WIDTH-3:0], q_nx[EXT_W:1]};
                    state_d   = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == CALC) || (state_d == DONE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            m_q         <= {EXT_W{1'b0}};
            q_q         <= {(EXT_W+1){1'b0}};
            acc_q       <= {EXT_W{1'b0}};
            product_q   <= {RESULT_WIDTH{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq (WIDTH=32): table-driven
// vectors, backpressure and mid-calculation reset sequences, and randomised
// transactions against a behavioural reference, with a result scoreboard.
module tb_booth_multiplier_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth_multiplier_seq_if #(.WIDTH(W)) bus ();

    booth_multiplier_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t           vecs[$];
    logic [2*W-1:0] exp_q[$];
    int             total = 0;
    int             bad   = 0;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end else begin
            return {32'd0, a} * {32'd0, b};
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge; returns #1 after the result handshake edge.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string nm);
        int n;
        int lat;
        logic [63:0] e;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) chk({nm, " in_ready_wait"}, 64'd0, 64'd1);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.is_signed    = s;
        bus.in_valid     = 1'b1;
        bus.out_ready    = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.is_signed    = ~s;
        chk({nm, " busy"}, 64'(bus.busy), 64'd1);
        chk({nm, " in_ready_low"}, 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'd17);
        e = exp_q.pop_front();
        chk({nm, " product"}, bus.product, e);
        @(posedge clk); #1;
        chk({nm, " in_ready_after"}, 64'(bus.in_ready), 64'd1);
        chk({nm, " out_valid_after"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] e;

        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.multiplicand = 32'd0;
        bus.multiplier   = 32'd0;
        bus.is_signed    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset product", bus.product, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        add_vec(32'd15,        -32'sd3,     1'b1, -64'sd45);
        add_vec(32'd12,        32'd5,       1'b1, 64'd60);
        add_vec(-32'sd7,       -32'sd6,     1'b1, 64'd42);
        add_vec(-32'sd8,       32'd9,       1'b1, -64'sd72);
        add_vec(32'd12345,     32'd6789,    1'b1, 64'd83810205);
        add_vec(-32'sd4567,    32'd2345,    1'b1, -64'sd10709615);
        add_vec(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        add_vec(32'h8000_0000, 32'd2,       1'b0, 64'h1_0000_0000);
        for (int m = 0; m < 2; m++) begin
            add_vec(32'd0,  32'd25, m[0], 64'd0);
            add_vec(32'd25, 32'd0,  m[0], 64'd0);
            add_vec(32'd1,  32'd50, m[0], 64'd50);
            add_vec(32'd50, 32'd1,  m[0], 64'd50);
        end
        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles, new operands ignored
        bus.multiplicand = 32'd1234;
        bus.multiplier   = -32'sd5678;
        bus.is_signed    = 1'b1;
        bus.in_valid     = 1'b1;
        bus.out_ready    = 1'b0;
        exp_q.push_back(-64'sd7006652);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp latency", 64'(lat), 64'd17);
        e = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp product c%0d", k), bus.product, e);
            chk($sformatf("bp out_valid c%0d", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp in_ready c%0d", k), 64'(bus.in_ready), 64'd0);
            bus.multiplicand = 32'd9;
            bus.multiplier   = 32'd9;
            bus.in_valid     = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        e = exp_q.pop_front();
        chk("bp product release", bus.product, e);
        chk("bp out_valid release", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        chk("bp out_valid after", 64'(bus.out_valid), 64'd0);
        chk("bp in_ready after", 64'(bus.in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp no stray txn", 64'(bus.busy), 64'd0);

        // Reset in the middle of CALC
        bus.multiplicand = 32'd1000;
        bus.multiplier   = 32'd1000;
        bus.is_signed    = 1'b0;
        bus.in_valid     = 1'b1;
        exp_q.push_back(64'd1000000);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst mid busy before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        chk("rst mid in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst mid out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst mid busy", 64'(bus.busy), 64'd0);
        chk("rst mid product", bus.product, 64'd0);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("rst mid aborted result", 64'(seen), 64'd0);
        do_txn(32'd3, 32'd4, 1'b1, 64'd12, "post-reset");

        // Randomised transactions, alternating mode
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            rs = i[0];
            do_txn(ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
